// File: rtl/edge_interval_counter_pkg.sv
// Shared types and defaults for the reciprocal period counter and its readout logic.
package edge_interval_counter_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_COUNT = 1'b1
  } state_t;

  localparam int DEFAULT_WIDTH     = 32;
  localparam int DEFAULT_N_PERIODS = 1;

  // Period index width; a single-period build still keeps a 1-bit index.
  function automatic int k_width(input int n_periods);
    return (n_periods > 1) ? $clog2(n_periods) : 1;
  endfunction

endpackage

// File: rtl/edge_interval_counter_if.sv
// Result channel: saturated cycle count, overflow flag, valid/ready handshake, sticky overrun.
interface edge_interval_counter_if
  import edge_interval_counter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic [WIDTH-1:0] result;
  logic             result_ovf;
  logic             result_valid;
  logic             result_ready;
  logic             overrun;

  modport master (
    output result,
    output result_ovf,
    output result_valid,
    output overrun,
    input  result_ready
  );

  modport slave (
    input  result,
    input  result_ovf,
    input  result_valid,
    input  overrun,
    output result_ready
  );

endinterface

// File: rtl/edge_interval_counter_rise_detect.sv
// Rising-edge detector on an already-synchronised input; the delay register runs every cycle.
module rise_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic in,
  output logic rise
);

  logic edge_d;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      edge_d <= 1'b0;
    end else begin
      edge_d <= in;
    end
  end

  assign rise = in & ~edge_d;

endmodule

// File: rtl/edge_interval_counter.sv
// Reciprocal period counter: counts clk cycles across N_PERIODS input periods and
// hands the saturated total to the readout side over a valid/ready channel.
module edge_interval_counter
  import edge_interval_counter_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter int N_PERIODS = DEFAULT_N_PERIODS
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic                    edge_in,
  edge_interval_counter_if.master bus
);

  localparam int               KW      = k_width(N_PERIODS);
  localparam logic [KW-1:0]    K_LAST  = KW'(N_PERIODS - 1);
  localparam logic [WIDTH-1:0] CNT_MAX = '1;

  state_t           state;
  logic [WIDTH-1:0] cnt;
  logic [KW-1:0]    k;
  logic             ovf_acc;

  logic [WIDTH-1:0] result_q;
  logic             result_ovf_q;
  logic             valid_q;
  logic             overrun_q;

  logic             rise;
  logic [WIDTH:0]   cnt_sum;
  logic [WIDTH-1:0] cnt_sat;
  logic             closing;
  logic             accept_new;
  logic             close_ovf;

  rise_detect u_rise_detect (
    .clk  (clk),
    .rst_n(rst_n),
    .in   (edge_in),
    .rise (rise)
  );

  // One extra bit catches the wrap so the count pins at all-ones instead.
  assign cnt_sum    = {1'b0, cnt} + {{WIDTH{1'b0}}, 1'b1};
  assign cnt_sat    = cnt_sum[WIDTH] ? CNT_MAX : cnt_sum[WIDTH-1:0];
  assign closing    = (state == ST_COUNT) && rise && (k == K_LAST);
  assign accept_new = !valid_q || bus.result_ready;
  assign close_ovf  = ovf_acc | (cnt == CNT_MAX);

  // NOTE: every register, including the held result, is cleared by the async reset so nothing stale escapes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      k            <= '0;
      ovf_acc      <= 1'b0;
      result_q     <= '0;
      result_ovf_q <= 1'b0;
      valid_q      <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      // Consumer side keeps running regardless of enable; a new load below overrides the drop.
      if (valid_q && bus.result_ready) begin
        valid_q <= 1'b0;
      end

      if (!enable) begin
        state     <= ST_IDLE;
        cnt       <= '0;
        k         <= '0;
        ovf_acc   <= 1'b0;
        overrun_q <= 1'b0;
      end else begin
        unique case (state)
          ST_IDLE: begin
            if (rise) begin
              state   <= ST_COUNT;
              cnt     <= '0;
              k       <= '0;
              ovf_acc <= 1'b0;
            end
          end

          ST_COUNT: begin
            if (closing) begin
              // The closing edge also opens the next window, so there is no dead time.
              cnt     <= '0;
              k       <= '0;
              ovf_acc <= 1'b0;
              if (accept_new) begin
                result_q     <= cnt_sat;
                result_ovf_q <= close_ovf;
                valid_q      <= 1'b1;
              end else begin
                overrun_q <= 1'b1;
              end
            end else begin
              cnt <= cnt_sat;
              if (cnt_sat == CNT_MAX) begin
                ovf_acc <= 1'b1;
              end
              if (rise) begin
                k <= k + KW'(1);
              end
            end
          end

          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  assign bus.result       = result_q;
  assign bus.result_ovf   = result_ovf_q;
  assign bus.result_valid = valid_q;
  assign bus.overrun      = overrun_q;

endmodule
